// File: rtl/knight_pkg.sv
// Shared constants and types for the knight's-tour command path.
package knight_pkg;

  localparam logic [3:0] MOVE    = 4'h4;
  localparam logic [3:0] MOVE_FF = 4'h5;
  localparam logic [3:0] TOUR    = 4'h6;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_POS  = 8'h5A;

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} tour_state_t;

  function automatic logic [15:0] mk_cmd(input logic [3:0] opc,
                                         input logic [7:0] hdg,
                                         input logic [2:0] sq);
    return {opc, hdg, 1'b0, sq};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a fanfare horizontal leg.
module knight_move_decode
  import knight_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        vld
);

  // Lowest set bit has priority so malformed multi-hot moves still decode.
  always_comb begin
    vld      = 1'b1;
    vert_cmd = '0;
    horz_cmd = '0;
    if (move[0]) begin
      vert_cmd = mk_cmd(MOVE, HDG_N, 3'd2);
      horz_cmd = mk_cmd(MOVE_FF, HDG_E, 3'd1);
    end else if (move[1]) begin
      vert_cmd = mk_cmd(MOVE, HDG_N, 3'd2);
      horz_cmd = mk_cmd(MOVE_FF, HDG_W, 3'd1);
    end else if (move[2]) begin
      vert_cmd = mk_cmd(MOVE, HDG_N, 3'd1);
      horz_cmd = mk_cmd(MOVE_FF, HDG_W, 3'd2);
    end else if (move[3]) begin
      vert_cmd = mk_cmd(MOVE, HDG_S, 3'd1);
      horz_cmd = mk_cmd(MOVE_FF, HDG_W, 3'd2);
    end else if (move[4]) begin
      vert_cmd = mk_cmd(MOVE, HDG_S, 3'd2);
      horz_cmd = mk_cmd(MOVE_FF, HDG_W, 3'd1);
    end else if (move[5]) begin
      vert_cmd = mk_cmd(MOVE, HDG_S, 3'd2);
      horz_cmd = mk_cmd(MOVE_FF, HDG_E, 3'd1);
    end else if (move[6]) begin
      vert_cmd = mk_cmd(MOVE, HDG_S, 3'd1);
      horz_cmd = mk_cmd(MOVE_FF, HDG_E, 3'd2);
    end else if (move[7]) begin
      vert_cmd = mk_cmd(MOVE, HDG_N, 3'd1);
      horz_cmd = mk_cmd(MOVE_FF, HDG_E, 3'd2);
    end else begin
      vld = 1'b0;
    end
  end

endmodule

// File: rtl/tour_cmd.sv
// Command-bus mux: UART pass-through when idle, two-leg knight moves during a tour.
module tour_cmd
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_t state, nxt_state;
  logic [4:0]  nxt_indx;
  logic [15:0] vert_cmd, horz_cmd;
  logic        move_vld;
  logic        last_move;

  knight_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .vld      (move_vld)
  );

  assign last_move = (mv_indx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= nxt_state;
      mv_indx <= nxt_indx;
    end
  end

  always_comb begin
    nxt_state        = state;
    nxt_indx         = mv_indx;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    unique case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          nxt_indx  = '0;
          nxt_state = VERT;
        end
      end
      VERT: begin
        // An empty move slot ends the tour early without offering a command.
        if (!move_vld) begin
          nxt_state = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) nxt_state = WAIT_V;
        end
      end
      WAIT_V: begin
        if (send_resp) nxt_state = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt_state = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (last_move) resp = RESP_DONE;
        if (send_resp) begin
          if (last_move) begin
            nxt_state = IDLE;
          end else begin
            nxt_indx  = mv_indx + 5'd1;
            nxt_state = VERT;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: decode table, randomized full tour, UART blocking, reset.
module tb_tour_cmd;

  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  logic [7:0]  tour_mem [0:31];
  assign move = tour_mem[mv_indx];

  tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Knight displacement per move bit: +dy is north, +dx is east.
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

  function automatic logic [15:0] ref_leg(input logic [7:0] mv, input bit horz);
    int b;
    int d;
    int mag;
    logic [7:0] hdg;
    b = -1;
    for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
    if (b < 0) return 16'h0000;
    d   = horz ? dx_tab[b] : dy_tab[b];
    mag = (d < 0) ? -d : d;
    if (horz) hdg = (d > 0) ? 8'hBF : 8'h3F;
    else      hdg = (d > 0) ? 8'h00 : 8'h7F;
    return {(horz ? 4'h5 : 4'h4), hdg, 1'b0, 3'(mag)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic count_en = 1'b0;
  int   rise_cnt = 0;
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (count_en && cmd_rdy && !prev_rdy) rise_cnt++;
    prev_rdy = cmd_rdy;
  end

  // One leg of a tour, answered by a processor model: clr after 3 clks, send_resp after 20.
  task automatic do_leg(input int k, input bit last);
    logic [15:0] exp;
    int t;
    exp = ref_leg(tour_mem[k/2], bit'(k % 2));
    @(negedge clk);
    t = 0;
    while (!cmd_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("leg_rdy", 16'(cmd_rdy), 16'h1);
    chk("leg_cmd", cmd, exp);
    chk("leg_idx", 16'(mv_indx), 16'(k/2));
    tick();
    tick();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    chk("uart_clr_blocked", 16'(clr_cmd_rdy_UART), 16'h0);
    tick();
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("wait_rdy_low", 16'(cmd_rdy), 16'h0);
    chk("wait_cmd_hold", cmd, exp);
    if (k == 10) begin
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
    end else begin
      tick();
    end
    repeat (17) tick();
    send_resp = 1'b1;
    if (last) count_en = 1'b0;
    @(negedge clk);
    chk("leg_resp", 16'(resp), last ? 16'h00A5 : 16'h005A);
    tick();
    send_resp = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int pc;
    tbl[0] = '{8'h01, 16'h4002, 16'h5BF1};
    tbl[1] = '{8'h02, 16'h4002, 16'h53F1};
    tbl[2] = '{8'h04, 16'h4001, 16'h53F2};
    tbl[3] = '{8'h08, 16'h47F1, 16'h53F2};
    tbl[4] = '{8'h10, 16'h47F2, 16'h53F1};
    tbl[5] = '{8'h20, 16'h47F2, 16'h5BF1};
    tbl[6] = '{8'h40, 16'h47F1, 16'h5BF2};
    tbl[7] = '{8'h80, 16'h4001, 16'h5BF2};
    tbl[8] = '{8'h24, 16'h4001, 16'h53F2};
    tbl[9] = '{8'hFF, 16'h4002, 16'h5BF1};
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h00;

    // Reset state
    cmd_UART = 16'h1234;
    tick();
    tick();
    chk("rst_idx", 16'(mv_indx), 16'h0);
    chk("rst_resp", 16'(resp), 16'h00A5);
    chk("rst_cmd", cmd, 16'h1234);
    chk("rst_rdy", 16'(cmd_rdy), 16'h0);
    rst_n = 1'b1;

    // UART pass-through
    cmd_UART = 16'h4001;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    chk("pt_cmd", cmd, 16'h4001);
    chk("pt_rdy", 16'(cmd_rdy), 16'h1);
    chk("pt_resp", 16'(resp), 16'h00A5);
    pc = 0;
    tick();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    pc += int'(clr_cmd_rdy_UART);
    tick();
    clr_cmd_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pc += int'(clr_cmd_rdy_UART);
    end
    chk("pt_clr_pulses", 16'(pc), 16'h1);
    cmd_rdy_UART = 1'b0;
    cmd_UART = 16'hFFFF;

    // Decode table: one-move tours terminated by an empty slot
    for (int i = 0; i < 10; i++) begin
      tour_mem[0] = tbl[i].mv;
      tour_mem[1] = 8'h00;
      tick();
      start_tour = 1'b1;
      @(negedge clk);
      chk("lat_pre", 16'(cmd_rdy), 16'h0);
      tick();
      start_tour = 1'b0;
      @(negedge clk);
      chk("tbl_vert", cmd, tbl[i].v);
      chk("tbl_vert_rdy", 16'(cmd_rdy), 16'h1);
      chk("tbl_resp", 16'(resp), 16'h005A);
      tick();
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      @(negedge clk);
      chk("spur_resp_cmd", cmd, tbl[i].v);
      chk("spur_resp_rdy", 16'(cmd_rdy), 16'h1);
      tick();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      @(negedge clk);
      chk("tbl_wv_rdy", 16'(cmd_rdy), 16'h0);
      tick();
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      @(negedge clk);
      chk("tbl_horz", cmd, tbl[i].h);
      chk("tbl_horz_rdy", 16'(cmd_rdy), 16'h1);
      tick();
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      tick();
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      @(negedge clk);
      chk("end_no_rdy", 16'(cmd_rdy), 16'h0);
      chk("end_idx", 16'(mv_indx), 16'h1);
      tick();
      @(negedge clk);
      chk("end_idle_resp", 16'(resp), 16'h00A5);
      chk("end_idle_cmd", cmd, 16'hFFFF);
    end

    // Full randomized tour with a pending UART command and a stray start_tour
    for (int i = 0; i < NUM_MOVES; i++)
      tour_mem[i] = (i < 8) ? 8'(1 << i) : 8'($urandom_range(1, 255));
    cmd_UART = 16'h4ABC;
    tick();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    count_en = 1'b1;
    cmd_rdy_UART = 1'b1;
    for (int k = 0; k < 2 * NUM_MOVES; k++) do_leg(k, k == 2 * NUM_MOVES - 1);
    @(negedge clk);
    chk("tour_rdy_count", 16'(rise_cnt), 16'd48);
    chk("post_cmd", cmd, 16'h4ABC);
    chk("post_rdy", 16'(cmd_rdy), 16'h1);
    chk("post_resp", 16'(resp), 16'h00A5);
    chk("post_idx", 16'(mv_indx), 16'd23);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("post_clr_fwd", 16'(clr_cmd_rdy_UART), 16'h1);
    tick();
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;

    // Asynchronous reset in WAIT_H of move 7
    for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'($urandom_range(1, 255));
    tick();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    for (int k = 0; k < 15; k++) do_leg(k, 1'b0);
    @(negedge clk);
    chk("rst_leg_cmd", cmd, ref_leg(tour_mem[7], 1'b1));
    tick();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("pre_rst_idx", 16'(mv_indx), 16'd7);
    chk("pre_rst_resp", 16'(resp), 16'h005A);
    cmd_UART = 16'h4001;
    cmd_rdy_UART = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_idx", 16'(mv_indx), 16'h0);
    chk("async_rst_resp", 16'(resp), 16'h00A5);
    chk("async_rst_cmd", cmd, 16'h4001);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd", cmd, 16'h4001);
    chk("rel_rdy", 16'(cmd_rdy), 16'h1);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("rel_clr_fwd", 16'(clr_cmd_rdy_UART), 16'h1);
    tick();
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("rel_idx", 16'(mv_indx), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Sits directly upstream of the command processor (cmd/cmd_rdy/clr_cmd_rdy/send_resp interface).
- In UART mode it passes BLE commands straight through.
- On tour_go it takes over the command bus. It splits each stored knight move into two legs: a vertical leg, then a horizontal leg. Each leg is issued as a command and the block waits for the processor's completion response before issuing the next.
- It also selects the response byte sent back over BLE.

Parameters:
- NUM_MOVES, 24: knight moves per tour. mv_indx runs 0..NUM_MOVES-1.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset
- start_tour  in  1  1-clk pulse from the command processor's tour_go
- move  in  8  one-hot knight move for the current mv_indx, from tour solution storage
- mv_indx  out  5  index of the current move
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume UART command
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  command valid to the command processor
- clr_cmd_rdy  in  1  command processor consumed cmd
- send_resp  in  1  command processor finished the command
- resp  out  8  response byte to UART wrapper

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset puts state in IDLE and mv_indx at 0. In IDLE the outputs are a combinational pass-through.
- Command format:
  - [15:12] opcode: 4'h4 = move, 4'h5 = move with fanfare.
  - [11:4] heading: N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF.
  - [3] is 0.
  - [2:0] number of squares.
- Vertical leg always uses opcode 4'h4. Horizontal leg always uses opcode 4'h5, so fanfare plays at the end of each knight move.
- Move decode (bit: vertical leg / horizontal leg):
  - bit0: N2 / E1
  - bit1: N2 / W1
  - bit2: N1 / W2
  - bit3: S1 / W2
  - bit4: S2 / W1
  - bit5: S2 / E1
  - bit6: S1 / E2
  - bit7: N1 / E2
  - More than one bit set: the lowest set bit wins.
  - move == 0: end of tour (see VERT).
- States:
  - IDLE:
    - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy, resp = 8'hA5.
    - start_tour: mv_indx <= 0, go to VERT.
  - VERT:
    - cmd = vertical leg, cmd_rdy = 1.
    - If move == 0, go to IDLE with no cmd_rdy pulse issued.
    - On clr_cmd_rdy, go to WAIT_V.
  - WAIT_V: cmd_rdy = 0; on send_resp, go to HORZ.
  - HORZ: cmd = horizontal leg, cmd_rdy = 1; on clr_cmd_rdy, go to WAIT_H.
  - WAIT_H: on send_resp:
    - If mv_indx == NUM_MOVES-1, go to IDLE.
    - Otherwise mv_indx++ and go to VERT.
- Response byte:
  - resp = 8'h5A in all tour states.
  - Exception: in WAIT_H with mv_indx == NUM_MOVES-1, resp = 8'hA5, so the final send_resp reports completion.
- Latency: start_tour asserted at edge N gives VERT and cmd_rdy = 1 visible after edge N+1.
- cmd and cmd_rdy are combinational from state, move and the IDLE pass-through. cmd is stable throughout a leg because mv_indx changes only on WAIT_H -> VERT.
- Tour in progress:
  - cmd_rdy_UART is ignored and clr_cmd_rdy_UART = 0, so a pending UART command waits until IDLE.
  - start_tour in any state other than IDLE is ignored.
- send_resp in VERT or HORZ (spurious) is ignored. clr_cmd_rdy in WAIT_V or WAIT_H is ignored.
- mv_indx width is 5 bits. It never wraps, because it is bounded by NUM_MOVES-1.
- rst_n low mid-tour: immediate return to IDLE with mv_indx = 0. Pass-through resumes the next cycle after release.

Decomposition:
- Package knight_pkg holds:
  - opcode constants MOVE = 4'h4, MOVE_FF = 4'h5, TOUR = 4'h6
  - heading constants HDG_N/W/S/E
  - RESP_DONE = 8'hA5, RESP_POS = 8'h5A
  - the tour state enum
- Sub-module: knight_move_decode. It is combinational: 8-bit one-hot in, two 16-bit leg commands plus a valid flag out. It is reused by the tour logic's move-legality checker.

Test Plan:
- UART passthrough: in IDLE, cmd_UART = 16'h4001, cmd_rdy_UART = 1, pulse clr_cmd_rdy -> cmd = 16'h4001, cmd_rdy = 1, clr_cmd_rdy_UART pulses once, resp = 8'hA5.
- Single move: NUM_MOVES = 1, move = 8'h01, start_tour:
  - VERT cmd = 16'h4002.
  - After clr_cmd_rdy and send_resp, HORZ cmd = 16'h5BF1.
  - On the final send_resp, resp = 8'hA5 and state returns to IDLE.
- Full tour:
  - NUM_MOVES = 24, cycling all 8 move bits; model answers clr_cmd_rdy after 3 clks and send_resp after 20.
  - Expect exactly 48 cmd_rdy assertions and the leg commands checked against the decode table.
  - mv_indx counts 0..23.
  - resp = 8'h5A on the first 47 responses and 8'hA5 on the last.
- UART blocked mid-tour: cmd_rdy_UART = 1 during WAIT_V -> clr_cmd_rdy_UART stays 0 and cmd shows the tour leg. After the tour ends, the UART cmd is forwarded.
- Boundaries:
  - move = 8'h00 in VERT -> IDLE next clk with no cmd_rdy.
  - move = 8'h24 -> decoded as bit2 (N1 then W2: 16'h4001, 16'h53F2).
  - Second start_tour mid-tour -> ignored.
- Reset in WAIT_H with mv_indx = 7 -> state IDLE and mv_indx = 0 asynchronously; pass-through active after release.
